// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds, optional
// first-word-fall-through read mode, occupancy count and sticky overflow/underflow flags.
module fifo_sync_param #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_wren,
    input  logic                       i_rden,
    input  logic [DATA_W-1:0]          i_wrdata,
    input  logic                       i_clr_err,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_alm_full,
    output logic                       o_alm_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [DATA_W-1:0]          o_rddata,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, alm_full_q, alm_empty_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_ok, rd_ok;

    // Accepts are qualified by the registered flags only, never by the same-cycle request.
    assign wr_ok = i_wren & ~full_q;
    assign rd_ok = i_rden & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A new error event wins over a same-cycle clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (i_wren && full_q) begin
            overflow_d = 1'b1;
        end
        if (i_rden && empty_q) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == CW'(DEPTH));
            empty_q     <= (count_d == '0);
            alm_full_q  <= (count_d >= CW'(AF_THRESH));
            alm_empty_q <= (count_d <= CW'(AE_THRESH));
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rstn) begin
            mem_q[wr_ptr_q] <= i_wrdata;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign o_rddata = mem_q[rd_ptr_q];
    end else begin : g_std
        logic [DATA_W-1:0] rddata_q;
        always_ff @(posedge clk) begin
            if (rstn) begin
                rddata_q <= '0;
            end else if (rd_ok) begin
                rddata_q <= mem_q[rd_ptr_q];
            end
        end
        assign o_rddata = rddata_q;
    end

    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_alm_full  = alm_full_q;
    assign o_alm_empty = alm_empty_q;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO: the next generation of the team's 128-bit FIFO block, generalised in data width and depth. It adds programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, an occupancy count and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, and the existing driver/monitor clocking style applies unchanged to its ports.

## Interface
- DATA_W, 128: data width in bits.
- DEPTH, 16: number of entries; must be a power of two and ≥ 4.
- AF_THRESH, DEPTH-2: o_alm_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: o_alm_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 selects standard read (data one cycle after the read); 1 selects fall-through (head word always presented).
- clk  in  1  the single clock; all logic is on the rising edge.
- rstn  in  1  reset, synchronous and active-high (1 = reset); only the name is inherited from the codebase.
- i_wren  in  1  write request.
- i_rden  in  1  read request.
- i_wrdata  in  DATA_W  write data.
- i_clr_err  in  1  clears the sticky error flags.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_alm_full  out  1  count ≥ AF_THRESH.
- o_alm_empty  out  1  count ≤ AE_THRESH.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_rddata  out  DATA_W  read data.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage is a DEPTH×DATA_W register array. Storage contents are not reset.
- Write and read pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally.
- Write accept (wr_ok) = i_wren & !o_full. Read accept (rd_ok) = i_rden & !o_empty. Both use the registered flags.
- A write while full is dropped: no storage or pointer change, and o_overflow is set.
- A read while empty is ignored: no pointer change, o_rddata unchanged, and o_underflow is set.
- Count update: count_next = count + wr_ok - rd_ok. Simultaneous accepted read and write leaves the count unchanged.
- In the full state, a simultaneous read and write accepts only the read, because o_full=1 blocks the write. That write raises o_overflow.
- In the empty state, a simultaneous read and write accepts only the write, and o_underflow is set.
- All four status flags and o_count are registered from count_next, so they are always mutually consistent.
- Error flags: set takes priority over i_clr_err in the same cycle. i_clr_err alone clears both flags on the next edge.
- FWFT=0: on rd_ok, o_rddata is loaded with mem[rd_ptr] at the same edge. Otherwise o_rddata holds its value.
- FWFT=1: o_rddata = mem[rd_ptr] combinationally. The value is valid whenever o_empty=0 and don't-care when empty. rd_ok advances to the next word.
- Reset (rstn=1 at an edge) forces the following, regardless of i_wren/i_rden in that cycle:
  - pointers = 0, o_count = 0
  - o_empty = 1, o_alm_empty = 1 (since AE_THRESH ≥ 0)
  - o_full = 0, o_alm_full = 0
  - o_overflow = 0, o_underflow = 0
  - o_rddata = 0 (FWFT=0 register)
- Reset mid-operation discards all queued words.

## Timing
- Write latency: a word written at edge N is readable from edge N+1, and o_empty falls at edge N.
- FWFT=1: the word appears on o_rddata in the cycle after edge N.
- FWFT=0: the word appears on o_rddata after the edge at which rd_ok is sampled. This gives 1-cycle read latency.
- o_full and o_alm_full update at the same edge as the write that crosses the threshold. There is no look-ahead.
- The first edge after rstn deasserts may accept a write.
- Full throughput is one write and one read per cycle, with no bubbles.

## Test plan
- Reset, then 16 writes of 0x1..0x10 (DEPTH=16, FWFT=0): o_count goes 1..16; o_alm_full rises with count=14; o_full rises with count=16; o_alm_empty falls with count=3.
- From full, write 0xDEAD: write is dropped, o_overflow=1, count stays 16. Then 16 reads return 0x1..0x10 in order, each one cycle after its read, and o_empty=1 at the end.
- Read while empty: o_underflow=1 and o_rddata unchanged. Assert i_clr_err together with another empty read: flag stays 1. i_clr_err alone: flag clears next cycle.
- Stream 40 words with i_wren=i_rden=1 every cycle starting at count=1: count stays 1, data is in order, and the pointers wrap twice with no loss.
- FWFT=1: write 0xA5 to an empty FIFO. Next cycle o_empty=0 and o_rddata=0xA5 without any read. After a read, o_empty=1.
- Assert rstn with 7 words queued while i_wren=1: after the edge o_count=0, o_empty=1, all outputs are at reset values, and the concurrent write is discarded.
